ser_rcvfifo: RTL
================

Name: ser_rcvfifo

Overview:
Serial receive front end for the serial line interface: 8N1 asynchronous receiver with input synchronizer, mid-bit sampling, start-glitch rejection, and a DEPTH-entry receive FIFO.
- Sits between the external rxd pin and the register interface.
- Presents the same read/ready/data_out handshake the register interface uses today, plus sticky overrun and framing-error flags.
- Bit timing comes from the shared 16-bit bit_len register (clock cycles per bit).

Parameters:
DEPTH, 4, FIFO entries; power of two, range 2..16.

Ports:
clk  input  1  system clock; all state changes on rising edge
rst  input  1  reset; asynchronous assertion, active-low (0 = reset)
bit_len  input  16  clock cycles per bit; legal range 4..65535
serial_in  input  1  raw asynchronous rxd line, idle high
read  input  1  pop head byte; ignored when ready=0
ready  output  1  FIFO non-empty
data_out  output  8  head-of-FIFO byte, valid while ready=1
overrun  output  1  sticky: a byte was dropped because the FIFO was full
frame_err  output  1  sticky: stop bit sampled as 0
clr_err  input  1  one-cycle pulse; clears overrun and frame_err

Behaviour:
Reset (rst=0, asynchronous):
- Synchronizer flops = 1; FSM = IDLE; counters = 0; FIFO empty.
- Outputs: ready=0, data_out=0, overrun=0, frame_err=0.

Synchronizer:
- Two flops on serial_in. FSM sees only the second flop (rx_s).
- Input latency is 2 cycles.

Timing counter (16-bit down-counter):
- Full-bit load = bit_len-1; half-bit load = (bit_len>>1)-1.
- "Tick" = counter at 0. At a tick the counter reloads for the next interval.
- bit_len is sampled only at loads; a mid-frame change takes effect at the next load.

FSM (IDLE, START, DATA, STOP):
- IDLE: when rx_s=0 -> START, load half-bit.
- START, at tick: rx_s=0 -> DATA, load full-bit, bitcnt=0. rx_s=1 -> IDLE (glitch; no flag, no push).
- DATA, at tick: shift rx_s in LSB-first (shreg <= {rx_s, shreg[7:1]}), bitcnt++, load full-bit. At the 8th tick -> STOP.
- STOP, at tick, always -> IDLE in the same cycle:
  - rx_s=1: push shreg.
  - rx_s=0: set frame_err, discard byte.
- A low line seen in IDLE the cycle after STOP starts a new frame, so back-to-back frames are supported.

FIFO (write/read pointers of log2(DEPTH)+1 bits):
- empty when pointers are equal; full when indices match and MSBs differ.
- data_out is combinational from mem[rd_ptr] (first-word fall-through). data_out is held when empty.
- Push-to-ready latency: ready=1 the cycle after the stop-bit tick.
- Pop: read=1 & ready=1 advances rd_ptr. read=1 & ready=0 has no effect.
- Push while full with no pop in the same cycle: byte dropped, overrun set, FIFO contents untouched.
- Push while full with a pop in the same cycle: both occur, no overrun.
- Push while empty with a read in the same cycle: the read is ignored (ready was 0).

Sticky flags:
- Set only by the events above. clr_err clears both.
- A set event in the same cycle as clr_err wins (flag ends 1).
- Reset mid-frame aborts the frame and empties the FIFO immediately.

Test Plan:
- bit_len=16, send 0xA5 with 8N1 timing -> exactly one push; ready rises 1 cycle after the stop tick; data_out=0xA5; read pulse -> ready=0.
- bit_len=16, serial_in low for 6 cycles then high -> FSM returns to IDLE; ready=0, frame_err=0.
- bit_len=16, send 0x3C with stop bit held 0 -> frame_err=1, ready=0; clr_err pulse -> frame_err=0; assert clr_err in the same cycle as a new framing error -> frame_err stays 1.
- DEPTH=4, bit_len=16, send 0x01..0x05 back-to-back with no reads -> FIFO holds 01,02,03,04; overrun=1; four reads return 01,02,03,04 in order, then ready=0.
- FIFO full, read asserted in the stop-tick cycle of a 5th byte 0x55 -> overrun=0; drained order 02,03,04,55.
- Drive rst=0 asynchronously in the middle of DATA, then release and send 0x81 -> outputs go to reset values without a clock edge; after release only 0x81 is received.

Source files
------------

// File: rtl/ser_rcvfifo.sv
// 8N1 serial receiver: two-flop input synchronizer, mid-bit sampling with start-glitch
// rejection, and a first-word fall-through receive FIFO with sticky error flags.
module ser_rcvfifo #(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] bit_len,
    input  logic        serial_in,
    input  logic        read,
    output logic        ready,
    output logic [7:0]  data_out,
    output logic        overrun,
    output logic        frame_err,
    input  logic        clr_err
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t        state;
    logic          sync_1, rx_s;
    logic [15:0]   cnt;
    logic [2:0]    bitcnt;
    logic [7:0]    shreg;
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [7:0]    mem [DEPTH];

    logic [15:0]   full_ld, half_ld;
    logic          tick, push_c, ferr_c, pop_c, empty, full;

    assign full_ld = bit_len - 16'd1;
    assign half_ld = (bit_len >> 1) - 16'd1;
    assign tick    = (cnt == 16'd0);
    assign push_c  = (state == STOP) && tick && rx_s;
    assign ferr_c  = (state == STOP) && tick && !rx_s;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign pop_c    = read && !empty;
    assign ready    = !empty;
    assign data_out = mem[rd_ptr[AW-1:0]];

    // Input synchronizer, idle-high.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_1 <= 1'b1;
            rx_s   <= 1'b1;
        end else begin
            sync_1 <= serial_in;
            rx_s   <= sync_1;
        end
    end

    // Frame FSM with bit-timing down-counter; counter reloads on every tick.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            cnt    <= 16'd0;
            bitcnt <= 3'd0;
            shreg  <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state <= START;
                        cnt   <= half_ld;
                    end
                end
                START: begin
                    if (tick) begin
                        if (!rx_s) begin
                            state  <= DATA;
                            cnt    <= full_ld;
                            bitcnt <= 3'd0;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                DATA: begin
                    if (tick) begin
                        shreg  <= {rx_s, shreg[7:1]};
                        bitcnt <= bitcnt + 3'd1;
                        cnt    <= full_ld;
                        if (bitcnt == 3'd7) state <= STOP;
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                STOP: begin
                    if (tick) begin
                        state <= IDLE;
                        cnt   <= 16'd0;
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Receive FIFO; a push into a full FIFO only lands when a pop frees the slot.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= 8'd0;
        end else begin
            if (push_c && (!full || pop_c)) begin
                mem[wr_ptr[AW-1:0]] <= shreg;
                wr_ptr              <= wr_ptr + PW'(1);
            end
            if (pop_c) rd_ptr <= rd_ptr + PW'(1);
        end
    end

    // Sticky flags; a set event beats a simultaneous clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (clr_err) begin
                overrun   <= 1'b0;
                frame_err <= 1'b0;
            end
            if (push_c && full && !pop_c) overrun <= 1'b1;
            if (ferr_c) frame_err <= 1'b1;
        end
    end

endmodule
